// File: rtl/ascensor_pkg.sv
// Shared encodings and default timing for the SCAN elevator controller.
package ascensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DOORS  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    localparam int DEF_TICKS_PER_FLOOR = 50_000_000;
    localparam int DEF_DOOR_TICKS      = 100_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ascensor_scan_if.sv
// Request strobe plus car status outputs of the elevator controller.
interface ascensor_scan_if #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = $clog2(N_FLOORS)
);
    logic                req_valid;
    logic [FLOOR_W-1:0]  req_floor;
    logic [FLOOR_W-1:0]  piso;
    logic [1:0]          direccion;
    logic                puertas_abiertas;
    logic                ocupado;
    logic [N_FLOORS-1:0] pendientes;

    modport master (
        output req_valid, req_floor,
        input  piso, direccion, puertas_abiertas, ocupado, pendientes
    );

    modport slave (
        input  req_valid, req_floor,
        output piso, direccion, puertas_abiertas, ocupado, pendientes
    );
endinterface

// File: rtl/ascensor_req_scan.sv
// Combinational view of the pending mask relative to the car: work above,
// below, at the current floor, and which way a SCAN sweep should head next.
module ascensor_req_scan #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
    input  logic [N_FLOORS-1:0] pendientes,
    input  logic [FLOOR_W-1:0]  piso,
    input  logic                dir_up,
    output logic                any_above,
    output logic                any_below,
    output logic                here,
    output logic                go_up
);
    logic [N_FLOORS-1:0] above_bits;
    logic [N_FLOORS-1:0] below_bits;
    logic [N_FLOORS-1:0] here_bits;

    genvar gi;
    generate
        for (gi = 0; gi < N_FLOORS; gi++) begin : g_floor
            assign above_bits[gi] = pendientes[gi] && (gi > int'(piso));
            assign below_bits[gi] = pendientes[gi] && (gi < int'(piso));
            assign here_bits[gi]  = pendientes[gi] && (gi == int'(piso));
        end
    endgenerate

    assign any_above = |above_bits;
    assign any_below = |below_bits;
    assign here      = |here_bits;

    // Keep the remembered heading while work lies ahead, otherwise turn around.
    assign go_up = dir_up ? (any_above || !any_below) : (any_above && !any_below);
endmodule

// File: rtl/ascensor_scan.sv
// SCAN elevator controller: IDLE / MOVING / DOORS FSM with a pending-request
// mask, a shared travel/door counter and fully registered outputs.
module ascensor_scan
    import ascensor_pkg::*;
#(
    parameter int N_FLOORS        = 4,
    parameter int FLOOR_W         = $clog2(N_FLOORS),
    parameter int TICKS_PER_FLOOR = DEF_TICKS_PER_FLOOR,
    parameter int DOOR_TICKS      = DEF_DOOR_TICKS
) (
    input  logic            clk,
    input  logic            rst_n,
    ascensor_scan_if.slave  bus
);
    localparam int CNT_W = $clog2(max_int(TICKS_PER_FLOOR, DOOR_TICKS) + 1);
    localparam logic [N_FLOORS-1:0] ONE_HOT0    = N_FLOORS'(1);
    localparam logic [FLOOR_W-1:0]  PISO_RST    = (N_FLOORS == 2) ? FLOOR_W'(0) : FLOOR_W'(1);
    localparam logic [CNT_W-1:0]    TRAVEL_LAST = CNT_W'(TICKS_PER_FLOOR - 1);
    localparam logic [CNT_W-1:0]    DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

    state_e              state_q, state_d;
    dir_e                dir_q, dir_d;
    logic                dir_up_q, dir_up_d;
    logic [FLOOR_W-1:0]  piso_q, piso_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_FLOORS-1:0] pend_q, pend_d;
    logic                puertas_q, puertas_d;
    logic                ocupado_q, ocupado_d;

    logic                req_ok;
    logic [N_FLOORS-1:0] req_mask, clear_mask, block_mask;
    logic                any_above, any_below, here, go_up;

    ascensor_req_scan #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_req_scan (
        .pendientes (pend_q),
        .piso       (piso_q),
        .dir_up     (dir_up_q),
        .any_above  (any_above),
        .any_below  (any_below),
        .here       (here),
        .go_up      (go_up)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        dir_up_d   = dir_up_q;
        piso_d     = piso_q;
        cnt_d      = cnt_q;
        clear_mask = '0;
        req_ok     = bus.req_valid && (int'(bus.req_floor) < N_FLOORS);
        req_mask   = req_ok ? (ONE_HOT0 << bus.req_floor) : '0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (here) begin
                    state_d    = ST_DOORS;
                    clear_mask = ONE_HOT0 << piso_q;
                    dir_d      = DIR_STOP;
                end else if (any_above || any_below) begin
                    state_d  = ST_MOVING;
                    dir_up_d = go_up;
                    dir_d    = go_up ? DIR_UP : DIR_DOWN;
                end else begin
                    dir_d = DIR_STOP;
                end
            end
            ST_MOVING: begin
                // Heading always points at a pending floor, so no end-floor overrun.
                if (cnt_q == TRAVEL_LAST) begin
                    cnt_d  = '0;
                    piso_d = dir_up_q ? piso_q + FLOOR_W'(1) : piso_q - FLOOR_W'(1);
                    if (|(pend_q & (ONE_HOT0 << piso_d))) begin
                        state_d    = ST_DOORS;
                        clear_mask = ONE_HOT0 << piso_d;
                        dir_d      = DIR_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DOORS: begin
                dir_d = DIR_STOP;
                if (req_ok && (bus.req_floor == piso_q)) begin
                    cnt_d = '0;
                end else if (cnt_q == DOOR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dir_d   = DIR_STOP;
                cnt_d   = '0;
            end
        endcase

        // A call for the floor whose doors are open, or being opened, is absorbed.
        block_mask = (state_q == ST_DOORS) ? (ONE_HOT0 << piso_q) : '0;
        pend_d     = (pend_q | (req_mask & ~block_mask)) & ~clear_mask;
        puertas_d  = (state_d == ST_DOORS);
        ocupado_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_STOP;
            dir_up_q  <= 1'b1;
            piso_q    <= PISO_RST;
            cnt_q     <= '0;
            pend_q    <= '0;
            puertas_q <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            dir_up_q  <= dir_up_d;
            piso_q    <= piso_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            puertas_q <= puertas_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign bus.piso             = piso_q;
    assign bus.direccion        = dir_q;
    assign bus.puertas_abiertas = puertas_q;
    assign bus.ocupado          = ocupado_q;
    assign bus.pendientes       = pend_q;
endmodule

// File: tb/tb_ascensor_scan.sv
// Bench for ascensor_scan: directed table, hand-written corner sequences and
// random requests, all checked every cycle against a behavioural car model.
module tb_ascensor_scan;
    localparam int N   = 4;
    localparam int FW  = 3;
    localparam int TPF = 4;
    localparam int DT  = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ascensor_scan_if #(.N_FLOORS(N), .FLOOR_W(FW)) bus ();

    ascensor_scan #(
        .N_FLOORS        (N),
        .FLOOR_W         (FW),
        .TICKS_PER_FLOOR (TPF),
        .DOOR_TICKS      (DT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit         v;
        int         fl;
        int         n;
        int         piso;
        logic [1:0] dir;
        bit         door;
        bit         busy;
        logic [N-1:0] pend;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: mode 0 idle, 1 travelling, 2 doors; heading +1 / -1.
    int m_mode, m_floor, m_heading, m_dir, m_timer;
    bit m_pend [N];

    bit rec_on = 1'b0;
    int stops[$];
    int legs[$];
    int prev_dir;
    bit prev_door;

    task automatic model_reset();
        m_mode = 0; m_floor = 1; m_heading = 1; m_dir = 0; m_timer = 0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
    endtask

    function automatic int pending_count();
        int c = 0;
        foreach (m_pend[i]) if (m_pend[i]) c++;
        return c;
    endfunction

    function automatic bit pending_side(input int side);
        foreach (m_pend[i]) if (m_pend[i] && ((i - m_floor) * side > 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] pend_mask();
        logic [N-1:0] pm;
        foreach (m_pend[i]) pm[i] = m_pend[i];
        return pm;
    endfunction

    task automatic model_edge(input bit v, input int f);
        bit ok;
        int clr, old_mode, old_floor;
        ok = v && (f < N);
        clr = -1; old_mode = m_mode; old_floor = m_floor;
        case (m_mode)
            0: begin
                m_timer = 0;
                if (m_pend[m_floor]) begin
                    clr = m_floor; m_mode = 2; m_dir = 0;
                end else if (pending_count() > 0) begin
                    if (!pending_side(m_heading)) m_heading = -m_heading;
                    m_mode = 1;
                    m_dir  = (m_heading > 0) ? 1 : 2;
                end else begin
                    m_dir = 0;
                end
            end
            1: begin
                if (m_timer == TPF - 1) begin
                    m_timer = 0;
                    m_floor = m_floor + m_heading;
                    if (m_pend[m_floor]) begin
                        clr = m_floor; m_mode = 2; m_dir = 0;
                    end
                end else begin
                    m_timer++;
                end
            end
            default: begin
                if (ok && f == m_floor) m_timer = 0;
                else if (m_timer == DT - 1) begin m_mode = 0; m_timer = 0; end
                else m_timer++;
            end
        endcase
        if (ok && f != clr && !(old_mode == 2 && f == old_floor)) m_pend[f] = 1'b1;
        if (clr >= 0) m_pend[clr] = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] pm;
        pm = pend_mask();
        n_vec++;
        if (bus.piso !== FW'(m_floor) || bus.direccion !== 2'(m_dir) ||
            bus.puertas_abiertas !== (m_mode == 2) || bus.ocupado !== (m_mode != 0) ||
            bus.pendientes !== pm) begin
            n_miss++;
            $display("FAIL %s vs model @%0t: got piso=%0d dir=%b doors=%b busy=%b pend=%b, want piso=%0d dir=%b doors=%b busy=%b pend=%b",
                     tag, $time, bus.piso, bus.direccion, bus.puertas_abiertas, bus.ocupado, bus.pendientes,
                     m_floor, 2'(m_dir), (m_mode == 2), (m_mode != 0), pm);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    task automatic tick(input bit v, input int f, input string tag);
        bus.req_valid = v;
        bus.req_floor = FW'(f);
        if (v) $display("req floor %0d (%s) @%0t", f, tag, $time);
        @(posedge clk);
        model_edge(v, f);
        #1;
        check_model(tag);
        if (rec_on) begin
            if (bus.puertas_abiertas && !prev_door) stops.push_back(int'(bus.piso));
            if (bus.direccion != 2'b00 && prev_dir == 0) legs.push_back(int'(bus.direccion));
        end
        prev_door = bus.puertas_abiertas;
        prev_dir  = int'(bus.direccion);
        bus.req_valid = 1'b0;
    endtask

    // Asserts rst_n between clock edges, checks the asynchronous response, then releases.
    task automatic do_reset(input string tag);
        bus.req_valid = 1'b0;
        bus.req_floor = '0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_model(tag);
        check_val({tag, "_piso"}, int'(bus.piso), 1);
        check_val({tag, "_pend"}, int'(bus.pendientes), 0);
        check_val({tag, "_busy"}, int'(bus.ocupado), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        prev_door = 1'b0;
        prev_dir  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   n;
        int   exp_stops [3];
        int   exp_legs [3];

        tbl[0] = '{1'b1, 3, 1, 1, 2'b00, 1'b0, 1'b0, 4'b1000};
        tbl[1] = '{1'b0, 0, 4, 1, 2'b01, 1'b0, 1'b1, 4'b1000};
        tbl[2] = '{1'b0, 0, 4, 2, 2'b01, 1'b0, 1'b1, 4'b1000};
        tbl[3] = '{1'b0, 0, 6, 3, 2'b00, 1'b1, 1'b1, 4'b0000};
        tbl[4] = '{1'b0, 0, 1, 3, 2'b00, 1'b0, 1'b0, 4'b0000};
        tbl[5] = '{1'b1, 5, 2, 3, 2'b00, 1'b0, 1'b0, 4'b0000};
        tbl[6] = '{1'b1, 2, 1, 3, 2'b00, 1'b0, 1'b0, 4'b0100};
        tbl[7] = '{1'b0, 0, 4, 3, 2'b10, 1'b0, 1'b1, 4'b0100};
        tbl[8] = '{1'b0, 0, 6, 2, 2'b00, 1'b1, 1'b1, 4'b0000};
        tbl[9] = '{1'b0, 0, 1, 2, 2'b00, 1'b0, 1'b0, 4'b0000};
        exp_stops = '{2, 3, 0};
        exp_legs  = '{1, 1, 2};

        bus.req_valid = 1'b0;
        bus.req_floor = '0;

        // Directed table: trip to 3, illegal floor 5, reverse trip to 2.
        do_reset("rst0");
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                tick(tbl[i].v, tbl[i].fl, "table");
                n_vec++;
                if (bus.piso !== FW'(tbl[i].piso) || bus.direccion !== tbl[i].dir ||
                    bus.puertas_abiertas !== tbl[i].door || bus.ocupado !== tbl[i].busy ||
                    bus.pendientes !== tbl[i].pend) begin
                    n_miss++;
                    $display("FAIL table[%0d] rep %0d: got piso=%0d dir=%b doors=%b busy=%b pend=%b, want piso=%0d dir=%b doors=%b busy=%b pend=%b",
                             i, r, bus.piso, bus.direccion, bus.puertas_abiertas, bus.ocupado, bus.pendientes,
                             tbl[i].piso, tbl[i].dir, tbl[i].door, tbl[i].busy, tbl[i].pend);
                end
            end
        end

        // SCAN order: heading up to 3, calls for 0 and 2 arrive on the way.
        do_reset("rst33");
        stops.delete();
        legs.delete();
        rec_on = 1'b1;
        tick(1'b1, 3, "scan");
        tick(1'b0, 0, "scan");
        tick(1'b1, 0, "scan");
        tick(1'b1, 2, "scan");
        for (int i = 0; i < 300 && stops.size() < 3; i++) tick(1'b0, 0, "scan");
        rec_on = 1'b0;
        check_val("scan_stop_count", stops.size(), 3);
        check_val("scan_leg_count", legs.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < stops.size()) check_val($sformatf("scan_stop%0d", i), stops[i], exp_stops[i]);
            if (i < legs.size())  check_val($sformatf("scan_leg%0d", i), legs[i], exp_legs[i]);
        end

        // Call for the current floor, then re-call while the doors are open.
        do_reset("rst34");
        tick(1'b1, 1, "same");
        tick(1'b0, 0, "same");
        check_val("same_doors", int'(bus.puertas_abiertas), 1);
        repeat (4) tick(1'b0, 0, "same");
        tick(1'b1, 1, "same_restart");
        n = 0;
        for (int i = 0; i < 20 && bus.puertas_abiertas; i++) begin
            n++;
            tick(1'b0, 0, "same");
        end
        check_val("same_restart_cycles", n, DT);
        check_val("same_piso", int'(bus.piso), 1);

        // Same-cycle call for the arrival floor is absorbed; doors open once.
        do_reset("rst37");
        tick(1'b1, 3, "arrive");
        tick(1'b1, 2, "arrive");
        repeat (3) tick(1'b0, 0, "arrive");
        tick(1'b1, 2, "arrive_same");
        check_val("arrive_piso", int'(bus.piso), 2);
        check_val("arrive_doors", int'(bus.puertas_abiertas), 1);
        check_val("arrive_pend", int'(bus.pendientes), 8);
        n = 0;
        for (int i = 0; i < 20 && bus.puertas_abiertas; i++) begin
            n++;
            tick(1'b0, 0, "arrive");
        end
        check_val("arrive_door_cycles", n, DT);
        for (int i = 0; i < 50 && !bus.puertas_abiertas; i++) tick(1'b0, 0, "arrive");
        check_val("arrive_next_stop", int'(bus.piso), 3);

        // Asynchronous reset while travelling between floors 2 and 3.
        do_reset("rst36a");
        tick(1'b1, 3, "midmove");
        for (int i = 0; i < 20 && bus.piso != FW'(2); i++) tick(1'b0, 0, "midmove");
        check_val("midmove_at2", int'(bus.piso), 2);
        tick(1'b1, 0, "midmove");
        tick(1'b0, 0, "midmove");
        do_reset("midmove_rst");
        repeat (3) tick(1'b0, 0, "post_rst");

        // Random calls, including out-of-range floors 4 and 5.
        do_reset("rst_rand");
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ascensor_scan.md
ASCENSOR_SCAN -- requirements
Module: ascensor_scan

Interface
REQ-001 Parameter N_FLOORS, default 4, number of floors; index 0 = lowest floor (basement -1), legal range 2..16.
REQ-002 Parameter FLOOR_W, default $clog2(N_FLOORS), floor index width.
REQ-003 Parameter TICKS_PER_FLOOR, default 50000000, clk cycles of travel per floor.
REQ-004 Parameter DOOR_TICKS, default 100000000, clk cycles doors stay open.
REQ-005 clk  input  1  sole clock, rising edge; one clock only.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  1  one-cycle strobe: a floor request is present.
REQ-008 req_floor  input  FLOOR_W  requested floor index, sampled when req_valid=1.
REQ-009 piso  output  FLOOR_W  current floor index.
REQ-010 direccion  output  2  00 stopped, 01 up, 10 down; 11 never driven.
REQ-011 puertas_abiertas  output  1  doors open.
REQ-012 ocupado  output  1  1 whenever state is not IDLE.
REQ-013 pendientes  output  N_FLOORS  registered bitmask of outstanding requests.

Function
REQ-014 Three-state FSM: IDLE, MOVING, DOORS; all outputs registered.
REQ-015 req_valid with req_floor >= N_FLOORS is ignored; no state change.
REQ-016 Valid request sets pendientes[req_floor] the next cycle, any state, except REQ-022/REQ-023 cases.
REQ-017 IDLE: if pendientes[piso]=1 -> DOORS next cycle, bit cleared; else if any bit set -> MOVING, direccion toward nearest pending floor above if direccion memory is up (else below); no pending -> stay, direccion=00.
REQ-018 Direction memory (SCAN): keep current direction while any pending bit lies strictly ahead; reverse only when none ahead and some behind; default up after reset.
REQ-019 MOVING: travel counter counts 0..TICKS_PER_FLOOR-1; on terminal count piso steps +/-1 and counter clears.
REQ-020 On arriving at floor f: if pendientes[f]=1 -> clear bit, DOORS, direccion=00; else continue per REQ-018.
REQ-021 piso never leaves 0..N_FLOORS-1; at an end floor with nothing ahead direction reverses per REQ-018, never steps past.
REQ-022 DOORS: puertas_abiertas=1; door counter counts 0..DOOR_TICKS-1, then IDLE with puertas_abiertas=0 the same edge.
REQ-023 Request for piso while in DOORS restarts door counter to 0; bit not set.
REQ-024 Request for piso in the same cycle the bit is being cleared on arrival is absorbed (bit stays 0).
REQ-025 Request for piso while MOVING between floors sets the bit normally (car has left).
REQ-026 Latency: IDLE request for another floor -> ocupado=1 and direccion valid 2 cycles after the req_valid edge; first floor step TICKS_PER_FLOOR cycles later.
REQ-027 Counters sized $clog2(max(TICKS_PER_FLOOR,DOOR_TICKS)+1); no wrap possible.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, piso=1 (floor 1; 0 if N_FLOORS=2), direccion=00, direction memory up, puertas_abiertas=0, ocupado=0, pendientes=0, counters 0.
REQ-029 Reset mid-MOVING or mid-DOORS discards all pending requests; operation resumes from IDLE on first clk after rst_n release.

Structure
REQ-030 Shared package ascensor_pkg holds state encoding (IDLE/MOVING/DOORS), direccion codes (STOP/UP/DOWN) and default tick constants.
REQ-031 One sub-module ascensor_req_scan: combinational, given pendientes, piso, direction memory -> any_above, any_below, here; FSM instantiates it once.

Verification (bench uses TICKS_PER_FLOOR=4, DOOR_TICKS=6, N_FLOORS=4)
REQ-032 Reset, req floor 3 -> direccion=01, piso 1->2->3 at 4-cycle steps, doors open 6 cycles, ocupado drops, pendientes=0.
REQ-033 At piso 1 moving up to 3, request 0 then 2 -> stops at 2, 3, then reverses, stops at 0; direccion 01,01,10 sequence.
REQ-034 IDLE at piso 1, request 1 -> DOORS without movement; request 1 again at door count 4 -> doors open 6 more cycles total from restart.
REQ-035 req_floor=5 with req_valid -> pendientes unchanged, state IDLE.
REQ-036 rst_n asserted mid-MOVING between floors 2 and 3 -> outputs immediately at reset values, pendientes=0.
REQ-037 Arrival at floor 2 with same-cycle request for 2 -> pendientes[2]=0 after, single door cycle.
